// File: rtl/vga_capture_if.sv
// Signal bundle between a 1-bit-per-colour VGA source and vga_capture.
// The master drives the raw stream and the slave returns the reconstructed pixels.
interface vga_capture_if;
  logic       r, g, b, hs, vs;
  logic       pix_valid, pix_r, pix_g, pix_b;
  logic [9:0] x, y;
  logic       frame_start, locked, sync_err;

  modport master (
    output r, g, b, hs, vs,
    input  pix_valid, pix_r, pix_g, pix_b, x, y, frame_start, locked, sync_err
  );
  modport slave (
    input  r, g, b, hs, vs,
    output pix_valid, pix_r, pix_g, pix_b, x, y, frame_start, locked, sync_err
  );
endinterface

// File: rtl/vga_capture.sv
// VGA receiver: rebuilds hpos/vpos from the syncs, verifies line and frame lengths
// and emits active pixels with x/y coordinates once the timing is locked.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input logic          clk,
  input logic          nReset,
  vga_capture_if.slave vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HA0     = H_SYNC + H_BP;
  localparam int VA0     = V_SYNC + V_BP;
  localparam int TO_I    = (2 * H_TOTAL > 2047) ? 2047 : 2 * H_TOTAL;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  logic        r_s, g_s, b_s, hs_s, vs_s, hs_d, vs_l;
  logic [10:0] hcnt, vcnt, hpos, vpos;
  logic        line_start, frame_f, timeout, line_bad, len_bad;
  state_t      state, state_n;
  logic [1:0]  good_cnt, good_n;
  logic        frame_bad, bad_n;
  logic        pv_n, err_n, in_win;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      {r_s, g_s, b_s, hs_s, vs_s, hs_d} <= '0;
    end else begin
      r_s  <= vga.r;
      g_s  <= vga.g;
      b_s  <= vga.b;
      hs_s <= vga.hs;
      vs_s <= vga.vs;
      hs_d <= hs_s;
    end
  end

  assign line_start = ~hs_s & hs_d;
  assign frame_f    = line_start & ~vs_s & vs_l;

  always_comb begin
    hpos = line_start ? 11'd0 : ((hcnt == 11'h7ff) ? hcnt : hcnt + 11'd1);
    vpos = vcnt;
    if (frame_f)         vpos = 11'd0;
    else if (line_start) vpos = (vcnt == 11'h7ff) ? vcnt : vcnt + 11'd1;
  end

  // hcnt/vcnt hold the position of the previous sample, so at a line start
  // they carry the last index of the line/frame that just ended
  assign timeout  = ~line_start & (hpos == 11'(TO_I));
  assign line_bad = line_start & (hcnt != 11'(H_TOTAL - 1));
  assign len_bad  = frame_f & (vcnt != 11'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      hcnt <= '0;
      vcnt <= '0;
      vs_l <= 1'b0;
    end else begin
      hcnt <= hpos;
      vcnt <= vpos;
      if (line_start) vs_l <= vs_s;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= SEARCH;
      good_cnt  <= '0;
      frame_bad <= 1'b0;
    end else begin
      state     <= state_n;
      good_cnt  <= good_n;
      frame_bad <= bad_n;
    end
  end

  always_comb begin
    state_n = state;
    good_n  = good_cnt;
    bad_n   = frame_bad;
    case (state)
      SEARCH: if (frame_f) begin
        state_n = CHECK;
        good_n  = '0;
        bad_n   = 1'b0;
      end
      CHECK: begin
        if (line_bad) bad_n = 1'b1;
        if (frame_f) begin
          bad_n = 1'b0;
          if (frame_bad | line_bad | len_bad) begin
            good_n = '0;
          end else begin
            good_n = good_cnt + 2'd1;
            if (good_n == 2'd2) state_n = LOCKED;
          end
        end
      end
      LOCKED: if (line_bad | len_bad) begin
        state_n = CHECK;
        good_n  = '0;
        // a mid-frame loss taints the frame in progress; at a frame start a fresh one begins
        bad_n   = ~frame_f;
      end
      default: state_n = SEARCH;
    endcase
    if (timeout) begin
      state_n = SEARCH;
      good_n  = '0;
      bad_n   = 1'b0;
    end
  end

  always_comb begin
    in_win = (hpos >= 11'(HA0)) && (hpos <= 11'(HA0 + H_ACTIVE - 1)) &&
             (vpos >= 11'(VA0)) && (vpos <= 11'(VA0 + V_ACTIVE - 1));
    pv_n   = (state_n == LOCKED) && in_win;
    err_n  = (state == LOCKED) && (line_bad || len_bad || timeout);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      vga.pix_valid   <= 1'b0;
      vga.pix_r       <= 1'b0;
      vga.pix_g       <= 1'b0;
      vga.pix_b       <= 1'b0;
      vga.x           <= '0;
      vga.y           <= '0;
      vga.frame_start <= 1'b0;
      vga.locked      <= 1'b0;
      vga.sync_err    <= 1'b0;
    end else begin
      vga.pix_valid   <= pv_n;
      vga.pix_r       <= pv_n & r_s;
      vga.pix_g       <= pv_n & g_s;
      vga.pix_b       <= pv_n & b_s;
      vga.x           <= hpos[9:0] - 10'(HA0);
      vga.y           <= vpos[9:0] - 10'(VA0);
      vga.frame_start <= frame_f;
      vga.locked      <= (state_n == LOCKED);
      vga.sync_err    <= err_n;
    end
  end
endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture with a 14x7 raster: acquisition, long line,
// short frame, stuck hsync and mid-frame reset.
module tb_vga_capture;
  logic clk, nReset;
  int   cyc;
  int   n_chk, n_fail;
  int   n_fs, n_err, n_rise, err_cyc, lock_rise, lock_fall;
  int   fcount, err_idx, stuck_idx;
  logic prev_locked;
  logic [2:0] hist_c [0:8191];
  int   hist_h [0:8191];
  int   hist_v [0:8191];
  int   hist_fr[0:8191];
  int   pv_cnt [0:63];
  int   fidx   [0:63];

  vga_capture_if bus();

  vga_capture #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk(clk), .nReset(nReset), .vga(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int outs();
    return int'({bus.pix_valid, bus.pix_r, bus.pix_g, bus.pix_b, bus.x, bus.y,
                 bus.frame_start, bus.locked, bus.sync_err});
  endfunction

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    int idx;
    idx = cyc - 2;
    if (bus.frame_start) n_fs++;
    if (bus.sync_err) begin
      n_err++;
      err_cyc = cyc;
      chk("pv_on_err", int'(bus.pix_valid), 0);
    end
    if (bus.locked && !prev_locked) begin n_rise++; lock_rise = cyc; end
    if (!bus.locked && prev_locked) lock_fall = cyc;
    prev_locked = bus.locked;
    if (bus.pix_valid && idx >= 0) begin
      chk("pix_rgb", int'({bus.pix_r, bus.pix_g, bus.pix_b}), int'(hist_c[idx]));
      chk("pix_x", int'(bus.x), hist_h[idx] - 4);
      chk("pix_y", int'(bus.y), hist_v[idx] - 2);
      pv_cnt[hist_fr[idx]]++;
    end else begin
      chk("pix_zero", int'({bus.pix_r, bus.pix_g, bus.pix_b}), 0);
    end
  end

  task automatic drive(input logic hsv, input logic vsv, input logic [2:0] c,
                       input int h, input int v);
    bus.hs = hsv;
    bus.vs = vsv;
    {bus.r, bus.g, bus.b} = c;
    hist_c[cyc]  = c;
    hist_h[cyc]  = h;
    hist_v[cyc]  = v;
    hist_fr[cyc] = fcount;
    @(posedge clk);
    #1;
  endtask

  // one frame: line 0 carries vs low; optional long line / mid-frame reset
  task automatic frame(input int nlines, input int long_v, input int rst_v);
    int len;
    fcount++;
    fidx[fcount] = cyc;
    for (int v = 0; v < nlines; v++) begin
      len = (v == long_v) ? 15 : 14;
      if (long_v >= 0 && v == long_v + 1) err_idx = cyc;
      for (int h = 0; h < len; h++) begin
        if (v == rst_v && h == 5) begin
          nReset = 1'b0;
          #1;
          chk("rst_async", outs(), 0);
        end
        if (v == rst_v && h == 8) nReset = 1'b1;
        drive(h >= 2, v != 0, 3'((h + v) & 7), h, v);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0; n_fs = 0; n_err = 0; n_rise = 0;
    err_cyc = -1; lock_rise = -1; lock_fall = -1; fcount = 0; prev_locked = 1'b0;
    err_idx = 0; stuck_idx = 0;
    for (int i = 0; i < 64; i++) pv_cnt[i] = 0;
    nReset = 1'b0;
    {bus.r, bus.g, bus.b, bus.hs, bus.vs} = '0;
    @(posedge clk);
    #1;
    // reset held with toggling inputs
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom), 1'($urandom), 3'($urandom), -100, -100);
      chk("rst_out", outs(), 0);
    end
    chk("rst_fs", n_fs, 0);
    nReset = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 3'b111, -100, -100);
    // preamble line with vs high, then clean acquisition
    for (int h = 0; h < 14; h++) drive(h >= 2, 1'b1, 3'b111, h, 6);
    for (int f = 0; f < 4; f++) frame(7, -1, -1);
    chk("acq_fs", n_fs, 4);
    chk("acq_lock_rise", lock_rise, fidx[3] + 2);
    chk("acq_pv_f2", pv_cnt[2], 0);
    chk("acq_pv_f4", pv_cnt[4], 32);
    frame(7, -1, -1);
    chk("acq_rises", n_rise, 1);
    chk("acq_no_err", n_err, 0);
    // long line while locked
    frame(7, 3, -1);
    for (int f = 0; f < 3; f++) frame(7, -1, -1);
    chk("long_err_n", n_err, 1);
    chk("long_err_cyc", err_cyc, err_idx + 2);
    chk("long_lock_fall", lock_fall, err_cyc);
    chk("long_relock", lock_rise, fidx[9] + 2);
    chk("long_rises", n_rise, 2);
    chk("long_pv_f6", pv_cnt[6], 16);
    chk("long_pv_f7", pv_cnt[7], 0);
    chk("long_pv_f8", pv_cnt[8], 0);
    // short frame while locked
    frame(6, -1, -1);
    chk("long_pv_f9", pv_cnt[9], 32);
    for (int f = 0; f < 3; f++) frame(7, -1, -1);
    chk("short_err_n", n_err, 2);
    chk("short_err_cyc", err_cyc, fidx[11] + 2);
    chk("short_lock_fall", lock_fall, err_cyc);
    chk("short_relock", lock_rise, fidx[13] + 2);
    chk("short_pv_f10", pv_cnt[10], 32);
    chk("short_pv_f11", pv_cnt[11], 0);
    // hs stuck high after two lines
    frame(2, -1, -1);
    stuck_idx = cyc;
    for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, 3'b111, -100, -100);
    chk("stuck_err_n", n_err, 3);
    chk("stuck_err_cyc", err_cyc, stuck_idx + 16);
    chk("stuck_lock_fall", lock_fall, err_cyc);
    chk("stuck_locked", int'(bus.locked), 0);
    for (int f = 0; f < 3; f++) frame(7, -1, -1);
    chk("stuck_relock", lock_rise, fidx[17] + 2);
    chk("stuck_pv_f16", pv_cnt[16], 0);
    chk("stuck_rises", n_rise, 4);
    // reset pulse mid-frame
    frame(7, -1, 3);
    chk("rstm_pv_f18", pv_cnt[18], 8);
    for (int f = 0; f < 3; f++) frame(7, -1, -1);
    chk("rstm_relock", lock_rise, fidx[21] + 2);
    chk("rstm_rises", n_rise, 5);
    chk("rstm_pv_f20", pv_cnt[20], 0);
    frame(7, -1, -1);
    chk("rstm_pv_f21", pv_cnt[21], 32);
    chk("total_fs", n_fs, 22);
    chk("total_err", n_err, 3);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_capture.md
# vga_capture

Receive-side counterpart of the `vga` timing generator. It samples an incoming 1-bit-per-colour VGA stream (`r`, `g`, `b`, `hs`, `vs`) on the pixel clock and reconstructs horizontal and vertical position from the sync pulses. It checks line and frame lengths against the configured timing and emits the active pixels with x/y coordinates once locked. It sits at the boundary between a VGA source (or the `vga` block in loopback) and downstream frame capture or checking logic.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hs pulse width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_ACTIVE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vs pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; both < 2048.
- `clk`  in  1  pixel clock, one sample per pixel
- `nReset`  in  1  asynchronous active-low reset
- `r`, `g`, `b`  in  1 each  colour inputs
- `hs`, `vs`  in  1 each  syncs, active low
- `pix_valid`  out  1  active pixel present on outputs
- `pix_r`, `pix_g`, `pix_b`  out  1 each  captured colour
- `x`  out  10  column, 0..H_ACTIVE-1
- `y`  out  10  row, 0..V_ACTIVE-1
- `frame_start`  out  1  one-cycle pulse at each detected frame start
- `locked`  out  1  timing verified
- `sync_err`  out  1  one-cycle pulse on timing loss while locked

## Operation
- Input stage: all five inputs registered once (`*_s`), plus one delayed copy of `hs_s` (`hs_d`).
- Line start L: `hs_s`=0 and `hs_d`=1. The sample with L has hpos 0; later samples increment hpos. hcnt is 11 bits and saturates at 2047.
- At each L: previous line length = last hpos + 1. vpos becomes 0 if `vs_s`=0 and the vs value latched at the previous L was 1 (frame start F). Otherwise vpos increments, saturating at 2047.
- Active window: hpos in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and vpos in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
- x = hpos - (H_SYNC+H_BP) and y = vpos - (V_SYNC+V_BP), truncated to 10 bits.
- FSM states:
  - SEARCH (reset state): first F -> CHECK, good_cnt=0.
  - CHECK: at each F, if the frame just ended had V_TOTAL lines and every line was H_TOTAL long, good_cnt++; otherwise good_cnt=0. good_cnt reaching 2 -> LOCKED.
  - LOCKED: any line-length mismatch at L, or frame-length mismatch at F -> CHECK with good_cnt=0, and `sync_err` pulses.
- A line-length mismatch seen in CHECK marks the current frame bad.
- Timeout: hpos reaching 2*H_TOTAL without L -> SEARCH from any state. `sync_err` pulses only if the FSM was LOCKED.
- `pix_valid` = LOCKED and inside the active window. `pix_r`/`pix_g`/`pix_b` are forced 0 when `pix_valid`=0.
- `frame_start` pulses on every F, in all states.
- Simultaneous L-mismatch and F on the same sample: treated as a single error, so one `sync_err` pulse.

## Timing
- Reset (async assert): all outputs 0, FSM SEARCH, counters 0, good_cnt 0. Release is synchronous to the next clk edge.
- Latency: a pin value at edge n is in `*_s` at n+1 and appears on the output registers at n+2. All outputs are registered.
- `locked` rises in the output cycle of the F sample that completes the second good frame, i.e. the 3rd F after leaving SEARCH.
- `locked` falls in the same output cycle as `sync_err`, aligned with the offending L or F sample.
- `pix_valid` is 0 for the output cycle that carries `sync_err`.
- Reset mid-operation: lock is discarded; reacquisition needs 3 frame starts.

## Test plan
Small parameters for all scenarios: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7).
- Reset:
  - Stimulus: hold nReset low with toggling inputs.
  - Response: all outputs 0; no `frame_start`.
- Clean acquisition:
  - Stimulus: 4 ideal frames with an r/g/b ramp.
  - Response: `frame_start` 4 times; `locked` rises 2 cycles after the 3rd F sample. Frame 4 gives exactly 32 `pix_valid` cycles, x 0..7 per row, y 0..3, colours equal to the inputs delayed 2 clocks.
- Long line:
  - Stimulus: one 15-clock line while locked.
  - Response: a single `sync_err` pulse and `locked`=0 at the following L. Relock at the 3rd subsequent F; no `pix_valid` in between.
- Short frame:
  - Stimulus: one frame of 6 lines while locked.
  - Response: `sync_err` at that F; `locked` drops.
- hs stuck high:
  - Stimulus: hs stuck high for 40 clocks while locked.
  - Response: `sync_err` pulse when hpos reaches 28; FSM in SEARCH; `locked`=0.
- Reset mid-frame:
  - Stimulus: pulse nReset low mid-frame while locked.
  - Response: outputs 0 immediately. After release, `locked` returns only after 3 F.
